// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow replaces a WIDTH-bit
// ripple subtractor. Start/busy/done handshake; results held between operations.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          operation request, sampled only while idle
//   a, b, bin      minuend, subtrahend, borrow-in (captured on accepted start)
//   busy           high while an operation is running or completing
//   done           one-cycle completion pulse
//   diff           a - b - bin mod 2^WIDTH
//   bout           final borrow (unsigned a < b + bin)
//   ovf            signed two's-complement overflow of a - (b + bin)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Holds the WIDTH-1 bits produced so far; the bit of the current step completes it.
    logic [WIDTH-2:0]   r_res;
    logic               r_brw;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_d;
    logic               w_brw_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    // Full-subtractor cell on the current LSBs
    assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    assign w_brw_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~r_a_sh[0] & r_brw) | (r_b_sh[0] & r_brw);
    assign w_res_nxt = {w_d, r_res};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_last;
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= b;
                r_res   <= '0;
                r_brw   <= bin;
                r_cnt   <= '0;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end else if (r_state == S_RUN) begin
                r_a_sh <= r_a_sh >> 1;
                r_b_sh <= r_b_sh >> 1;
                r_res  <= w_res_nxt[WIDTH-1:1];
                r_brw  <= w_brw_nxt;
                r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_brw_nxt;
                // Overflow only possible when operand signs differ and the result sign leaves a's
                r_ovf  <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, bout, diff}
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int ux, uy, ud, sx, sy, sd;
        logic [W-1:0] d;
        logic bo, ov;
        ux = int'(x);
        uy = int'(y);
        ud = ux - uy - int'(c);
        d  = W'(ud);
        bo = (ud < 0);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        sd = sx - sy - int'(c);
        ov = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
        return {ov, bo, d};
    endfunction

    // Transaction-level model: age counts clock edges since the accepted start
    int           cyc = 0;
    int           m_age = -1;
    logic [W-1:0] m_a = '0, m_b = '0, m_diff = '0;
    logic         m_bin = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
    int           acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age  <= -1;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_age < 0) begin
            if (start) begin
                m_a   <= a;
                m_b   <= b;
                m_bin <= bin;
                m_age <= 0;
                acc_cyc.push_back(cyc);
            end
        end else if (m_age == W - 1) begin
            {m_ovf, m_bout, m_diff} <= ref_sub(m_a, m_b, m_bin);
            m_age <= W;
        end else if (m_age == W) begin
            m_age <= -1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    int busy_run = 0;
    int last_busy_len = 0;
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_age >= 0));
        chk("done", 32'(done), 32'(m_age == W));
        chk("diff", 32'(diff), 32'(m_diff));
        chk("bout", 32'(bout), 32'(m_bout));
        chk("ovf",  32'(ovf),  32'(m_ovf));
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          input bit lit, input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        n = 0;
        @(negedge clk);
        a = ai; b = bi; bin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        while (done !== 1'b1 && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            chk("done_timeout", 32'(done), 32'(1));
        end else if (lit) begin
            chk("lit_diff", 32'(diff), 32'(ed));
            chk("lit_bout", 32'(bout), 32'(eb));
            chk("lit_ovf",  32'(ovf),  32'(eo));
        end
        @(negedge clk);
    endtask

    initial begin
        // Pin the reference model with hand-computed values
        chk("ref_35_12", 32'(ref_sub(8'h35, 8'h12, 1'b0)), 32'({1'b0, 1'b0, 8'h23}));
        chk("ref_12_35", 32'(ref_sub(8'h12, 8'h35, 1'b0)), 32'({1'b0, 1'b1, 8'hDD}));
        chk("ref_00_00_1", 32'(ref_sub(8'h00, 8'h00, 1'b1)), 32'({1'b0, 1'b1, 8'hFF}));
        chk("ref_80_01", 32'(ref_sub(8'h80, 8'h01, 1'b0)), 32'({1'b1, 1'b0, 8'h7F}));
        chk("ref_7F_FF", 32'(ref_sub(8'h7F, 8'hFF, 1'b0)), 32'({1'b1, 1'b1, 8'h80}));
        chk("ref_7F_FF_1", 32'(ref_sub(8'h7F, 8'hFF, 1'b1)), 32'({1'b0, 1'b1, 8'h7F}));

        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_bout", 32'(bout), 32'(0));
        chk("rst_ovf",  32'(ovf),  32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        #1;
        chk("busy_len", 32'(last_busy_len), 32'(W + 1));
        run_op(8'h12, 8'h35, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
        run_op(8'h80, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

        // start held high with operands changing every cycle
        acc_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        repeat (45) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("held_accepts", 32'(acc_cyc.size()), 32'(5));
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("held_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(W + 2));
        end

        // Asynchronous reset in the middle of an operation
        run_op(8'h35, 8'h12, 1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'(1));
        chk("mid_held_diff", 32'(diff), 32'(8'h23));
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_diff", 32'(diff), 32'(0));
        chk("arst_bout", 32'(bout), 32'(0));
        chk("arst_ovf",  32'(ovf),  32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);

        // Random operations, checked by the model every cycle
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 1'b0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing a - b - bin one bit per clock, LSB first.
- Each step uses a single full-subtractor cell with a registered borrow, the borrow-propagating counterpart of the team's combinational full adder.
- Used in area-constrained datapaths where a WIDTH-bit ripple subtractor is too large.
- Start/busy/done handshake; result, borrow and signed-overflow flag are held until the next operation completes.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled on accepted start
b  input  WIDTH  subtrahend; sampled on accepted start
bin  input  1  borrow-in; sampled on accepted start
busy  output  1  high while state != IDLE
done  output  1  one-cycle completion pulse
diff  output  WIDTH  result a-b-bin mod 2^WIDTH
bout  output  1  final borrow (unsigned a < b+bin)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy, done, bout and ovf = 0; diff = 0.
  - All internal shift/count/borrow registers are cleared.
  - Any in-flight operation is discarded; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a rising edge: load a_sh=a, b_sh=b, brw=bin, cnt=0, a_msb=a[WIDTH-1], b_msb=b[WIDTH-1]; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - d = a_sh[0]^b_sh[0]^brw.
  - brw <= (~a_sh[0]&b_sh[0]) | (~a_sh[0]&brw) | (b_sh[0]&brw).
  - Working result shifts right with d inserted at the MSB; a_sh and b_sh shift right; cnt++.
  - At the edge processing bit WIDTH-1 (cnt==WIDTH-1):
    - diff <= completed result; bout <= final brw.
    - ovf <= (a_msb != b_msb) & (result_msb != a_msb).
    - done <= 1; go to DONE.
- DONE: done <= 0; go to IDLE at the next edge.
- Latency: start sampled at edge k, done high in the cycle after edge k+WIDTH. A new start is accepted at earliest edge k+WIDTH+2.
- busy is high in RUN and DONE.
- start is ignored while busy, including in the cycle done is high. Changes on a, b or bin during busy have no effect.
- diff, bout and ovf change only at the completion edge and are held otherwise, including across a new start until that operation completes.
- bin is included in ovf: the result is treated as a WIDTH-bit signed a - (b + bin).
- Counter width is clog2(WIDTH); no wrap beyond WIDTH-1.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0, start 1 cycle -> after 8 RUN cycles: done pulses once, diff=0x23, bout=0, ovf=0; busy high exactly 9 cycles.
- a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- start held high continuously, with a/b changed every cycle while busy -> results match the operands captured at each accepted start; starts are accepted exactly every 10 cycles; done never asserts twice within one operation.
- Complete a=0x35, b=0x12 (diff=0x23 held). Start a=0x10, b=0x01, then assert rst at RUN cycle 4 -> busy=0, done=0, diff=0x00, bout=0, ovf=0 immediately, without waiting for a clock edge. Post-reset start a=0x10, b=0x01 -> diff=0x0F.
- Randomised 1000 operations vs. reference model ((a-b-bin) mod 256, borrow, signed overflow) -> zero mismatches.
